// File: rtl/lcd_cmd_if.sv
// Bundle between the LSU io_LCD register (master) and the LCD command driver
// (slave). Signal names match the board-level LCD pin names.
interface lcd_cmd_if;
  logic [31:0] io_lcd;    // [31]=ON, [9]=REQ toggle, [8]=RS, [7:0]=DATA
  logic        lcd_on;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic        lcd_busy;
  logic        lcd_ack;

  modport master (
    output io_lcd,
    input  lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, lcd_busy, lcd_ack
  );

  modport slave (
    input  io_lcd,
    output lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, lcd_busy, lcd_ack
  );
endinterface

// File: rtl/lcd_cmd_driver.sv
// HD44780-style command driver: each REQ toggle on io_lcd becomes one 8-bit
// parallel write (setup, EN pulse, hold, execution wait). Completion is
// signalled by toggling lcd_ack so firmware can poll ack == REQ.
module lcd_cmd_driver #(
  parameter int unsigned T_SETUP      = 4,
  parameter int unsigned T_EN_HIGH    = 12,
  parameter int unsigned T_HOLD       = 2,
  parameter int unsigned T_EXEC_SHORT = 2000,
  parameter int unsigned T_EXEC_LONG  = 80000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic        clk,
  input  logic        rst,
  lcd_cmd_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_EXEC
  } state_t;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN_HI = CNT_W'(T_EN_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(T_EXEC_SHORT - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

  state_t           state_q;
  logic [CNT_W-1:0] timer_q;
  logic             on_q;
  logic             en_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             busy_q;
  logic             ack_q;

  logic             pending_d;
  logic             long_cmd_d;
  logic             timer_done_d;
  logic [CNT_W-1:0] exec_load_d;
  logic             unused_bits;

  // Command pending whenever the REQ toggle disagrees with our ack toggle.
  assign pending_d    = bus.io_lcd[9] ^ ack_q;
  // Clear (0x01), home (0x02/0x03) and 0x00 need the long execution wait.
  assign long_cmd_d   = ~rs_q && (data_q[7:1] == 7'b0000000 || data_q[7:1] == 7'b0000001);
  assign exec_load_d  = long_cmd_d ? LD_LONG : LD_SHORT;
  assign timer_done_d = (timer_q == '0);
  assign unused_bits  = ^bus.io_lcd[30:10];

  // Single FSM: sequences one LCD write per command with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      on_q    <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      // Power bit is a plain registered copy, independent of the sequencer.
      on_q <= bus.io_lcd[31];
      unique case (state_q)
        S_IDLE: begin
          if (pending_d) begin
            rs_q    <= bus.io_lcd[8];
            data_q  <= bus.io_lcd[7:0];
            busy_q  <= 1'b1;
            timer_q <= LD_SETUP;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (timer_done_d) begin
            en_q    <= 1'b1;
            timer_q <= LD_EN_HI;
            state_q <= S_EN_HI;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_EN_HI: begin
          if (timer_done_d) begin
            en_q    <= 1'b0;
            timer_q <= LD_HOLD;
            state_q <= S_HOLD;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (timer_done_d) begin
            timer_q <= exec_load_d;
            state_q <= S_EXEC;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_EXEC: begin
          if (timer_done_d) begin
            ack_q   <= ~ack_q;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign bus.lcd_on   = on_q;
  assign bus.lcd_en   = en_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_data = data_q;
  assign bus.lcd_busy = busy_q;
  assign bus.lcd_ack  = ack_q;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Randomized bench for lcd_cmd_driver. Each command is checked against
// expectations derived from the timing rules: EN window position/length,
// total busy length (short vs long exec), latched RS/DATA, ack toggle.
module tb_lcd_cmd_driver;

  localparam int T_SETUP = 2, T_EN_HIGH = 3, T_HOLD = 1;
  localparam int T_EXEC_SHORT = 5, T_EXEC_LONG = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic req_tb = 1'b0;
  logic ack_exp = 1'b0;
  logic on_at_edge = 1'b0;

  lcd_cmd_if bus ();

  lcd_cmd_driver #(
    .T_SETUP(T_SETUP), .T_EN_HIGH(T_EN_HIGH), .T_HOLD(T_HOLD),
    .T_EXEC_SHORT(T_EXEC_SHORT), .T_EXEC_LONG(T_EXEC_LONG), .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge and check lcd_on
  // against the ON bit that was present at that edge.
  task automatic tick();
    on_at_edge = bus.io_lcd[31];
    @(posedge clk);
    #1;
    check_val("lcd_on", bus.lcd_on, on_at_edge);
    check_val("lcd_rw", bus.lcd_rw, 0);
  endtask

  // Issue one command by flipping REQ and follow it to completion.
  task automatic run_cmd(input logic rs, input logic [7:0] d, input bit perturb);
    int exp_exec, exp_busy, n, en_cnt, en_first;
    exp_exec = (!rs && d[7:1] <= 7'd1) ? T_EXEC_LONG : T_EXEC_SHORT;
    exp_busy = T_SETUP + T_EN_HIGH + T_HOLD + exp_exec;
    req_tb = ~req_tb;
    bus.io_lcd = {bus.io_lcd[31], 21'b0, req_tb, rs, d};
    tick();
    check_val("busy_start", bus.lcd_busy, 1);
    n = 0; en_cnt = 0; en_first = 0;
    while (bus.lcd_busy && n < 200) begin
      n++;
      if (bus.lcd_en) begin
        en_cnt++;
        if (en_first == 0) en_first = n;
      end
      check_val("lcd_data", bus.lcd_data, d);
      check_val("lcd_rs", bus.lcd_rs, rs);
      if (perturb) begin
        if (n == 2) bus.io_lcd[9] = ~bus.io_lcd[9];
        if (n == 4) bus.io_lcd[8:0] = {bus.io_lcd[9], ~rs, 8'hFF};
        if (n == 6) bus.io_lcd[9] = req_tb;
        if (n == 7) bus.io_lcd[31] = ~bus.io_lcd[31];
      end
      tick();
    end
    ack_exp = req_tb;
    $display("cmd rs=%0b data=0x%02h busy=%0d/%0d en=%0d@%0d ack=%0b", rs, d, n, exp_busy,
             en_cnt, en_first, bus.lcd_ack);
    check_val("busy_len", n, exp_busy);
    check_val("en_len", en_cnt, T_EN_HIGH);
    check_val("en_first", en_first, T_SETUP + 1);
    check_val("en_after", bus.lcd_en, 0);
    check_val("ack", bus.lcd_ack, ack_exp);
  endtask

  initial begin
    logic       rs;
    logic [7:0] d;
    int         en_seen;
    bus.io_lcd = 32'h0;

    // Reset state and quiet idle.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_en", bus.lcd_en, 0);
    check_val("rst_busy", bus.lcd_busy, 0);
    check_val("rst_ack", bus.lcd_ack, 0);
    check_val("rst_data", bus.lcd_data, 0);
    check_val("rst_rs", bus.lcd_rs, 0);
    check_val("rst_on", bus.lcd_on, 0);
    rst = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.lcd_en || bus.lcd_busy) en_seen++;
    end
    check_val("idle_quiet", en_seen, 0);

    // Directed commands.
    run_cmd(1'b0, 8'h41, 1'b0);
    run_cmd(1'b1, 8'h01, 1'b0);
    run_cmd(1'b0, 8'h01, 1'b0);
    run_cmd(1'b0, 8'h38, 1'b1);   // mid-command data change, double REQ flip, ON toggle
    tick();
    check_val("no_requeue", bus.lcd_busy, 0);
    run_cmd(1'b0, 8'h00, 1'b0);
    run_cmd(1'b0, 8'h03, 1'b1);

    // Randomized commands with idle gaps and ON toggles.
    for (int k = 0; k < 14; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 1) bus.io_lcd[31] = ~bus.io_lcd[31];
        tick();
        check_val("idle_busy", bus.lcd_busy, 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        rs = 1'b0;
        d  = 8'($urandom_range(0, 3));
      end else begin
        rs = 1'($urandom_range(0, 1));
        d  = 8'($urandom_range(0, 255));
      end
      run_cmd(rs, d, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset during EN_HI.
    bus.io_lcd[31] = 1'b0;
    tick();
    req_tb = ~req_tb;
    bus.io_lcd = {1'b0, 21'b0, req_tb, 1'b1, 8'h5A};
    for (int i = 0; i < 4; i++) tick();
    check_val("pre_rst_en", bus.lcd_en, 1);
    #2;
    rst = 1'b1;
    bus.io_lcd = 32'h0;
    req_tb = 1'b0;
    #1;
    check_val("async_en", bus.lcd_en, 0);
    check_val("async_busy", bus.lcd_busy, 0);
    check_val("async_ack", bus.lcd_ack, 0);
    $display("async reset en=%0b busy=%0b ack=%0b", bus.lcd_en, bus.lcd_busy, bus.lcd_ack);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.lcd_en || bus.lcd_busy) en_seen++;
    end
    check_val("post_rst_idle", en_seen, 0);
    run_cmd(1'b1, 8'hC3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
